// File: rtl/decode_issue.sv
// RV32I decode-and-issue stage: decodes OP, OP-IMM, LUI and AUIPC and presents the
// result through a main register backed by a one-entry skid register.
package decode_issue_pkg;
    typedef logic [31:0] arch_reg;

    typedef enum logic [3:0] {
        ADD         = 4'd0,
        SUB         = 4'd1,
        SLL_SLLI1   = 4'd2,
        SLT_SLTI1   = 4'd3,
        SLTU_SLTIU1 = 4'd4,
        XOR1        = 4'd5,
        SRL_SRLI    = 4'd6,
        SRA_SRAI    = 4'd7,
        OR1         = 4'd8,
        AND1        = 4'd9
    } exec_op_e;

    typedef enum logic {OP1_REG = 1'b0, OP1_PC  = 1'b1} op1_sel_e;
    typedef enum logic {OP2_REG = 1'b0, OP2_IMM = 1'b1} op2_sel_e;

    typedef struct packed {
        op1_sel_e op1_sel;
        op2_sel_e op2_sel;
        exec_op_e exec_op;
    } exec_unit_params;

    typedef struct packed {
        arch_reg         pc;
        arch_reg         imm;
        logic [4:0]      rs1_idx;
        logic [4:0]      rs2_idx;
        logic [4:0]      rd_idx;
        logic            rd_we;
        exec_unit_params params;
        logic            illegal;
    } issue_entry_t;
endpackage

module decode_issue
    import decode_issue_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    input  arch_reg         in_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output arch_reg         out_pc,
    output arch_reg         out_imm,
    output logic [4:0]      out_rs1_idx,
    output logic [4:0]      out_rs2_idx,
    output logic [4:0]      out_rd_idx,
    output logic            out_rd_we,
    output exec_unit_params out_params,
    output logic            out_illegal
);
    localparam logic [6:0] OPC_OP    = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI   = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC = 7'b0010111;

    function automatic exec_op_e f3_op(input logic [2:0] f3);
        exec_op_e op;
        case (f3)
            3'b000:  op = ADD;
            3'b001:  op = SLL_SLLI1;
            3'b010:  op = SLT_SLTI1;
            3'b011:  op = SLTU_SLTIU1;
            3'b100:  op = XOR1;
            3'b101:  op = SRL_SRLI;
            3'b110:  op = OR1;
            default: op = AND1;
        endcase
        return op;
    endfunction

    logic [6:0]   opcode;
    logic [2:0]   funct3;
    logic [6:0]   funct7;
    logic         legal;
    issue_entry_t dec;

    assign opcode = in_instr[6:0];
    assign funct3 = in_instr[14:12];
    assign funct7 = in_instr[31:25];

    always_comb begin
        dec    = '0;
        dec.pc = in_pc;
        legal  = 1'b0;
        case (opcode)
            OPC_OP: begin
                dec.rs1_idx        = in_instr[19:15];
                dec.rs2_idx        = in_instr[24:20];
                dec.rd_idx         = in_instr[11:7];
                dec.params.op1_sel = OP1_REG;
                dec.params.op2_sel = OP2_REG;
                if (funct7 == 7'b0000000) begin
                    legal              = 1'b1;
                    dec.params.exec_op = f3_op(funct3);
                end else if (funct7 == 7'b0100000 && funct3 == 3'b000) begin
                    legal              = 1'b1;
                    dec.params.exec_op = SUB;
                end else if (funct7 == 7'b0100000 && funct3 == 3'b101) begin
                    legal              = 1'b1;
                    dec.params.exec_op = SRA_SRAI;
                end
            end
            OPC_OPIMM: begin
                dec.rs1_idx        = in_instr[19:15];
                dec.rd_idx         = in_instr[11:7];
                dec.imm            = {{20{in_instr[31]}}, in_instr[31:20]};
                dec.params.op1_sel = OP1_REG;
                dec.params.op2_sel = OP2_IMM;
                dec.params.exec_op = f3_op(funct3);
                legal              = 1'b1;
                // funct7 only qualifies the shift encodings
                if (funct3 == 3'b001 && funct7 != 7'b0000000) begin
                    legal = 1'b0;
                end
                if (funct3 == 3'b101) begin
                    if (funct7 == 7'b0100000) begin
                        dec.params.exec_op = SRA_SRAI;
                    end else if (funct7 != 7'b0000000) begin
                        legal = 1'b0;
                    end
                end
            end
            OPC_LUI, OPC_AUIPC: begin
                dec.rd_idx         = in_instr[11:7];
                dec.imm            = {in_instr[31:12], 12'b0};
                dec.params.op1_sel = (opcode == OPC_AUIPC) ? OP1_PC : OP1_REG;
                dec.params.op2_sel = OP2_IMM;
                dec.params.exec_op = ADD;
                legal              = 1'b1;
            end
            default: legal = 1'b0;
        endcase

        if (!legal) begin
            dec         = '0;
            dec.pc      = in_pc;
            dec.illegal = 1'b1;
        end else begin
            dec.rd_we = (dec.rd_idx != 5'd0);
        end
    end

    issue_entry_t main_q, main_d, skid_q, skid_d;
    logic         main_valid_q, main_valid_d, skid_valid_q, skid_valid_d;
    logic         accept, drain;

    assign in_ready = !skid_valid_q && !rst;
    assign accept   = in_valid && in_ready;
    assign drain    = main_valid_q && out_ready;

    always_comb begin
        main_d       = main_q;
        skid_d       = skid_q;
        main_valid_d = main_valid_q;
        skid_valid_d = skid_valid_q;
        if (flush) begin
            main_valid_d = 1'b0;
            skid_valid_d = 1'b0;
        end else if (!main_valid_q || drain) begin
            // skid is older than any new input, so it refills main first
            if (skid_valid_q) begin
                main_d       = skid_q;
                main_valid_d = 1'b1;
                skid_valid_d = accept;
                if (accept) begin
                    skid_d = dec;
                end
            end else begin
                main_valid_d = accept;
                if (accept) begin
                    main_d = dec;
                end
            end
        end else if (accept) begin
            skid_d       = dec;
            skid_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            main_q       <= '0;
            skid_q       <= '0;
            main_valid_q <= 1'b0;
            skid_valid_q <= 1'b0;
        end else begin
            main_q       <= main_d;
            skid_q       <= skid_d;
            main_valid_q <= main_valid_d;
            skid_valid_q <= skid_valid_d;
        end
    end

    assign out_valid   = main_valid_q;
    assign out_pc      = main_q.pc;
    assign out_imm     = main_q.imm;
    assign out_rs1_idx = main_q.rs1_idx;
    assign out_rs2_idx = main_q.rs2_idx;
    assign out_rd_idx  = main_q.rd_idx;
    assign out_rd_we   = main_q.rd_we;
    assign out_params  = main_q.params;
    assign out_illegal = main_q.illegal;
endmodule

// File: tb/tb_decode_issue.sv
// Scoreboard bench for decode_issue: a reference decoder predicts each accepted
// instruction and the entry is compared when the stage hands it downstream.
module tb_decode_issue;
    import decode_issue_pkg::*;

    logic            clk = 1'b0;
    logic            rst, flush, in_valid, in_ready, out_valid, out_ready;
    logic [31:0]     in_instr;
    arch_reg         in_pc, out_pc, out_imm;
    logic [4:0]      out_rs1_idx, out_rs2_idx, out_rd_idx;
    logic            out_rd_we, out_illegal;
    exec_unit_params out_params;

    decode_issue dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
        .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_imm(out_imm),
        .out_rs1_idx(out_rs1_idx), .out_rs2_idx(out_rs2_idx), .out_rd_idx(out_rd_idx),
        .out_rd_we(out_rd_we), .out_params(out_params), .out_illegal(out_illegal)
    );

    always #5 clk = ~clk;

    int unsigned  n_tests = 0;
    int unsigned  n_fail  = 0;
    issue_entry_t exp_q[$];
    issue_entry_t obs, prev_obs;
    logic         prev_stall = 1'b0;
    logic [31:0]  pc = 32'h0000_1000;

    always_comb begin
        obs         = '0;
        obs.pc      = out_pc;
        obs.imm     = out_imm;
        obs.rs1_idx = out_rs1_idx;
        obs.rs2_idx = out_rs2_idx;
        obs.rd_idx  = out_rd_idx;
        obs.rd_we   = out_rd_we;
        obs.params  = out_params;
        obs.illegal = out_illegal;
    end

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic issue_entry_t model(input logic [31:0] ins, input logic [31:0] ipc);
        issue_entry_t e;
        exec_op_e     ops [8];
        logic [6:0]   f7;
        logic [2:0]   f3;
        logic         ok;
        ops = '{ADD, SLL_SLLI1, SLT_SLTI1, SLTU_SLTIU1, XOR1, SRL_SRLI, OR1, AND1};
        f7 = ins[31:25];
        f3 = ins[14:12];
        ok = 1'b1;
        e = '0;
        e.pc = ipc;
        e.rd_idx = ins[11:7];
        case (ins[6:0])
            7'h33: begin
                e.rs1_idx = ins[19:15];
                e.rs2_idx = ins[24:20];
                e.params  = '{OP1_REG, OP2_REG, ops[f3]};
                if (f7 == 7'h20) begin
                    if (f3 == 3'd0)      e.params.exec_op = SUB;
                    else if (f3 == 3'd5) e.params.exec_op = SRA_SRAI;
                    else                 ok = 1'b0;
                end else if (f7 != 7'h00) ok = 1'b0;
            end
            7'h13: begin
                e.rs1_idx = ins[19:15];
                e.imm     = {{20{ins[31]}}, ins[31:20]};
                e.params  = '{OP1_REG, OP2_IMM, ops[f3]};
                if (f3 == 3'd1 && f7 != 7'h00) ok = 1'b0;
                if (f3 == 3'd5) begin
                    if (f7 == 7'h20)      e.params.exec_op = SRA_SRAI;
                    else if (f7 != 7'h00) ok = 1'b0;
                end
            end
            7'h37: begin
                e.imm    = {ins[31:12], 12'h000};
                e.params = '{OP1_REG, OP2_IMM, ADD};
            end
            7'h17: begin
                e.imm    = {ins[31:12], 12'h000};
                e.params = '{OP1_PC, OP2_IMM, ADD};
            end
            default: ok = 1'b0;
        endcase
        if (!ok) begin
            e         = '0;
            e.pc      = ipc;
            e.illegal = 1'b1;
        end else begin
            e.rd_we = (e.rd_idx != 5'd0);
        end
        return e;
    endfunction

    // scoreboard: pop on output handshake, push on input handshake
    always @(negedge clk) begin
        if (rst || flush) begin
            exp_q.delete();
            prev_stall = 1'b0;
        end else begin
            issue_entry_t e;
            if (prev_stall) check_eq("stall_hold", 128'(obs), 128'(prev_obs));
            if (out_valid) check_eq("sb_nonempty", 128'(exp_q.size() != 0), 128'(1));
            if (out_valid && out_ready && exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check_eq("sb_entry", 128'(obs), 128'(e));
            end
            if (in_valid && in_ready) exp_q.push_back(model(in_instr, in_pc));
            prev_stall = out_valid && !out_ready;
            prev_obs   = obs;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [31:0] ins);
        in_valid = 1'b1;
        in_instr = ins;
        in_pc    = pc;
        pc       = pc + 32'd4;
    endtask

    // hold the offered instruction until accepted, bounded
    task automatic send(input logic [31:0] ins);
        bit done = 1'b0;
        drive(ins);
        for (int i = 0; i < 50 && !done; i++) begin
            @(negedge clk);
            done = in_ready;
            step();
        end
        if (!done) check_eq("send_timeout", 128'(done), 128'(1));
    endtask

    task automatic issue_one(input logic [31:0] ins);
        send(ins);
        in_valid = 1'b0;
        @(negedge clk);
    endtask

    task automatic drain();
        bit empty = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 20 && !empty; i++) begin
            @(negedge clk);
            empty = !out_valid;
            step();
        end
        check_eq("drained", 128'(empty), 128'(1));
    endtask

    function automatic logic [31:0] rand_instr();
        logic [31:0] r;
        r = $urandom;
        case ($urandom_range(0, 5))
            0: r[6:0] = 7'h33;
            1: r[6:0] = 7'h13;
            2: r[6:0] = 7'h37;
            3: r[6:0] = 7'h17;
            4: begin r[6:0] = 7'h13; r[14:12] = 3'd5; end
            default: ;
        endcase
        case ($urandom_range(0, 2))
            0: r[31:25] = 7'h00;
            1: r[31:25] = 7'h20;
            default: ;
        endcase
        return r;
    endfunction

    initial begin
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        in_instr = '0; in_pc = '0;
        step();
        step();
        @(negedge clk);
        check_eq("rst_in_ready", 128'(in_ready), 128'(0));
        check_eq("rst_out_valid", 128'(out_valid), 128'(0));
        check_eq("rst_outputs", 128'(obs), 128'(0));
        step();
        rst = 1'b0;
        @(negedge clk);
        check_eq("post_rst_in_ready", 128'(in_ready), 128'(1));
        step();

        issue_one(32'hFFF30293);
        check_eq("addi_valid", 128'(out_valid), 128'(1));
        check_eq("addi_imm", 128'(out_imm), 128'(32'hFFFF_FFFF));
        check_eq("addi_rs1", 128'(out_rs1_idx), 128'(6));
        check_eq("addi_rd", 128'(out_rd_idx), 128'(5));
        check_eq("addi_we", 128'(out_rd_we), 128'(1));
        check_eq("addi_params", 128'(out_params), 128'({OP1_REG, OP2_IMM, ADD}));
        check_eq("addi_illegal", 128'(out_illegal), 128'(0));
        step();

        begin
            logic [31:0] b2b [4];
            b2b[0] = 32'h403100B3;
            b2b[1] = 32'h40345393;
            b2b[2] = 32'h12345537;
            b2b[3] = 32'h12345517;
            for (int k = 0; k < 4; k++) begin
                drive(b2b[k]);
                if (k == 3) in_pc = 32'h0000_0100;
                @(negedge clk);
                check_eq("b2b_in_ready", 128'(in_ready), 128'(1));
                if (k > 0) check_eq("b2b_out_valid", 128'(out_valid), 128'(1));
                if (k == 1) begin
                    check_eq("sub_rs1", 128'(out_rs1_idx), 128'(2));
                    check_eq("sub_rs2", 128'(out_rs2_idx), 128'(3));
                    check_eq("sub_rd", 128'(out_rd_idx), 128'(1));
                    check_eq("sub_op", 128'(out_params.exec_op), 128'(SUB));
                end
                if (k == 2) begin
                    check_eq("srai_op2", 128'(out_params.op2_sel), 128'(OP2_IMM));
                    check_eq("srai_shamt", 128'(out_imm[4:0]), 128'(3));
                    check_eq("srai_op", 128'(out_params.exec_op), 128'(SRA_SRAI));
                end
                if (k == 3) begin
                    check_eq("lui_imm", 128'(out_imm), 128'(32'h1234_5000));
                    check_eq("lui_rs1", 128'(out_rs1_idx), 128'(0));
                    check_eq("lui_params", 128'(out_params), 128'({OP1_REG, OP2_IMM, ADD}));
                end
                step();
            end
            in_valid = 1'b0;
            @(negedge clk);
            check_eq("auipc_valid", 128'(out_valid), 128'(1));
            check_eq("auipc_op1", 128'(out_params.op1_sel), 128'(OP1_PC));
            check_eq("auipc_pc", 128'(out_pc), 128'(32'h100));
            step();
        end

        issue_one(32'h02000033);
        check_eq("ill_op_flag", 128'(out_illegal), 128'(1));
        check_eq("ill_op_we", 128'(out_rd_we), 128'(0));
        check_eq("ill_op_idx", 128'({out_rs1_idx, out_rs2_idx, out_rd_idx}), 128'(0));
        step();
        issue_one(32'h0000007F);
        check_eq("ill_opc_flag", 128'(out_illegal), 128'(1));
        check_eq("ill_opc_params", 128'(out_params), 128'(0));
        step();
        issue_one(32'h00208033);
        check_eq("add_x0_legal", 128'(out_illegal), 128'(0));
        check_eq("add_x0_we", 128'(out_rd_we), 128'(0));
        step();

        // backpressure: two fit, third stalls until the skid drains
        out_ready = 1'b0;
        send(32'h00100093);
        send(32'h00200113);
        drive(32'h00300193);
        @(negedge clk);
        check_eq("skid_full_in_ready", 128'(in_ready), 128'(0));
        step();
        step();
        step();
        out_ready = 1'b1;
        send(32'h00300193);
        drain();

        for (int k = 0; k < 120; k++) begin
            out_ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 3) != 0) drive(rand_instr());
            else in_valid = 1'b0;
            step();
        end
        drain();

        out_ready = 1'b0;
        send(32'h00500293);
        send(32'h00600313);
        drive(32'h00700393);
        flush = 1'b1;
        step();
        flush = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        check_eq("flush_out_valid", 128'(out_valid), 128'(0));
        check_eq("flush_in_ready", 128'(in_ready), 128'(1));
        out_ready = 1'b1;
        step();
        step();
        @(negedge clk);
        check_eq("flush_no_ghost", 128'(out_valid), 128'(0));
        step();

        out_ready = 1'b0;
        send(32'h00800413);
        send(32'h00900493);
        drive(32'h00A00513);
        rst = 1'b1;
        @(negedge clk);
        check_eq("rst_mid_in_ready", 128'(in_ready), 128'(0));
        step();
        rst = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        check_eq("rst_mid_out_valid", 128'(out_valid), 128'(0));
        check_eq("rst_mid_outputs", 128'(obs), 128'(0));
        check_eq("rst_mid_in_ready_after", 128'(in_ready), 128'(1));
        step();

        out_ready = 1'b1;
        issue_one(32'h00B00593);
        step();
        drain();
        check_eq("sb_final_empty", 128'(exp_q.size()), 128'(0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
